// File: rtl/testdrive_apb_reg_bank.sv
// APB4 completer register bank: ID, CTRL, W1C STATUS, loadable COUNTER and byte-writable SCRATCH.
// Optional protocol checker enabled by defining APB_REG_BANK_PROTOCOL_CHECK_EN.
module testdrive_apb_reg_bank #(
  parameter int          C_ADDR_BITS     = 10,
  parameter int          C_WAIT_CYCLES   = 0,
  parameter int          C_SCRATCH_COUNT = 4,
  parameter logic [31:0] C_ID            = 32'hA9B0_0001
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [C_ADDR_BITS-1:0] PADDR,
  input  logic [31:0]            PWDATA,
  input  logic [3:0]             PSTRB,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic                   IRQ
);

  localparam int         SCR_IW    = (C_SCRATCH_COUNT > 1) ? $clog2(C_SCRATCH_COUNT) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(C_WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_r;
  state_t              phase_s;
  state_t              state_nxt_s;
  logic [3:0]          wait_r;
  logic [3:0]          wait_nxt_s;
  logic [1:0]          ctrl_r;
  logic [2:0]          status_r;
  logic [31:0]         counter_r;
  logic [31:0]         scratch_r [C_SCRATCH_COUNT];

  logic                pready_s;
  logic [31:0]         word_s;
  logic                scr_hit_s;
  logic                legal_s;
  logic [SCR_IW-1:0]   scr_idx_s;
  logic [31:0]         rdata_s;
  logic                wr_s;
  logic                wr_ctrl_s;
  logic                wr_stat_s;
  logic                wr_cnt_s;
  logic                wr_scr_s;
  logic                ovf_s;
  logic                err_s;
  logic                viol_s;
  logic [2:0]          w1c_s;
  logic                unused_s;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    return (old_v & ~strb_mask(strb)) | (new_v & strb_mask(strb));
  endfunction

  // Bus phase of the current cycle: a setup cycle is seen directly on PSEL/PENABLE outside ACCESS,
  // so the registered FSM reaches ACCESS in the second cycle of a transfer.
  always_comb begin
    if (state_r == ACCESS) begin
      phase_s = ACCESS;
    end else if (PSEL && !PENABLE) begin
      phase_s = SETUP;
    end else begin
      phase_s = IDLE;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt_s = IDLE;
    wait_nxt_s  = wait_r;
    case (phase_s)
      SETUP: begin
        state_nxt_s = ACCESS;
        wait_nxt_s  = WAIT_INIT;
      end
      ACCESS: begin
        if (!PSEL) begin
          state_nxt_s = IDLE;
        end else if (wait_r != 4'd0) begin
          state_nxt_s = ACCESS;
          wait_nxt_s  = wait_r - 4'd1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state and wait counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      wait_r  <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
    end
  end

  // A dropped PSEL aborts the access, so it also masks PREADY
  assign pready_s  = (state_r == ACCESS) && (wait_r == 4'd0) && PSEL;
  assign word_s    = 32'(PADDR[C_ADDR_BITS-1:2]);
  assign scr_hit_s = (word_s >= 32'd4) && ((word_s - 32'd4) < 32'(C_SCRATCH_COUNT));
  assign legal_s   = (word_s < 32'd4) || scr_hit_s;
  assign scr_idx_s = SCR_IW'(word_s - 32'd4);
  assign unused_s  = ^PADDR[1:0];

  // Read-data decode
  always_comb begin
    rdata_s = 32'd0;
    case (word_s)
      32'd0: rdata_s = C_ID;
      32'd1: rdata_s = {30'd0, ctrl_r};
      32'd2: rdata_s = {29'd0, status_r};
      32'd3: rdata_s = counter_r;
      default: begin
        if (scr_hit_s) begin
          rdata_s = scratch_r[scr_idx_s];
        end else begin
          rdata_s = 32'd0;
        end
      end
    endcase
  end

  assign PREADY  = pready_s;
  assign PSLVERR = pready_s && !legal_s;
  assign PRDATA  = (pready_s && legal_s) ? rdata_s : 32'd0;
  assign IRQ     = status_r[0] & ctrl_r[1];

  assign wr_s      = pready_s && PWRITE && legal_s;
  assign wr_ctrl_s = wr_s && (word_s == 32'd1) && PSTRB[0];
  assign wr_stat_s = wr_s && (word_s == 32'd2);
  assign wr_cnt_s  = wr_s && (word_s == 32'd3);
  assign wr_scr_s  = wr_s && scr_hit_s;
  assign err_s     = pready_s && !legal_s;
  assign ovf_s     = ctrl_r[0] && (counter_r == 32'hFFFF_FFFF) && !wr_cnt_s;
  assign w1c_s     = wr_stat_s ? (PWDATA[2:0] & {3{PSTRB[0]}}) : 3'd0;

`ifdef APB_REG_BANK_PROTOCOL_CHECK_EN
  logic [C_ADDR_BITS-1:0] addr_q_r;
  logic                   write_q_r;
  logic [31:0]            wdata_q_r;
  logic [3:0]             strb_q_r;

  // Capture transfer attributes in the setup cycle for the stability check
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q_r  <= '0;
      write_q_r <= 1'b0;
      wdata_q_r <= 32'd0;
      strb_q_r  <= 4'd0;
    end else if (phase_s == SETUP) begin
      addr_q_r  <= PADDR;
      write_q_r <= PWRITE;
      wdata_q_r <= PWDATA;
      strb_q_r  <= PSTRB;
    end else begin
      addr_q_r  <= addr_q_r;
      write_q_r <= write_q_r;
      wdata_q_r <= wdata_q_r;
      strb_q_r  <= strb_q_r;
    end
  end

  // Protocol violation detection
  always_comb begin
    viol_s = 1'b0;
    if ((state_r == IDLE) && PSEL && PENABLE) begin
      viol_s = 1'b1;
    end else if ((state_r == ACCESS) && PSEL && !PENABLE) begin
      viol_s = 1'b1;
    end else if ((state_r == ACCESS) && PSEL &&
                 ((PADDR != addr_q_r) || (PWRITE != write_q_r) ||
                  (PWDATA != wdata_q_r) || (PSTRB != strb_q_r))) begin
      viol_s = 1'b1;
    end else begin
      viol_s = 1'b0;
    end
  end

  // Report each violation cycle with its timestamp
  always_ff @(posedge CLK) begin
    if (nRST && viol_s) begin
      $error("apb_reg_bank protocol violation at %0t", $time);
    end
  end
`else
  assign viol_s = 1'b0;
`endif

  // CTRL register: only the low byte lane matters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctrl_r <= 2'd0;
    end else if (wr_ctrl_s) begin
      ctrl_r <= PWDATA[1:0];
    end
  end

  // STATUS: sticky flags, a new set beats a simultaneous W1C
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      status_r <= 3'd0;
    end else begin
      status_r <= (status_r & ~w1c_s) | {viol_s, err_s, ovf_s};
    end
  end

  // COUNTER: a bus write beats the increment
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      counter_r <= 32'd0;
    end else if (wr_cnt_s) begin
      counter_r <= byte_merge(counter_r, PWDATA, PSTRB);
    end else if (ctrl_r[0]) begin
      counter_r <= counter_r + 32'd1;
    end
  end

  // SCRATCH registers with per-byte strobes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < C_SCRATCH_COUNT; i++) begin
        scratch_r[i] <= 32'd0;
      end
    end else if (wr_scr_s) begin
      scratch_r[scr_idx_s] <= byte_merge(scratch_r[scr_idx_s], PWDATA, PSTRB);
    end
  end

endmodule
